// File: rtl/acc_datapath_if.sv
// Control word, preload port and status bundle between the accumulator CPU controller and its datapath.
// Purely combinational wiring; no latency or flow control of its own.
interface acc_datapath_if #(
   parameter int AW = 5,
   parameter int DW = 8
);
   logic          MemRead;
   logic          MemWrite;
   logic          ldIR;
   logic          ldMDR;
   logic          ldAcc;
   logic          IorD;
   logic          Asrc;
   logic          AccSrc;
   logic          PCsrc;
   logic          PCwrite;
   logic          jz;
   logic [1:0]    ALUop;
   logic [1:0]    Bsrc;
   logic          init_we;
   logic [AW-1:0] init_addr;
   logic [DW-1:0] init_data;
   logic [2:0]    opcode;
   logic          zero;
   logic [DW-1:0] acc_out;
   logic [AW-1:0] pc_out;

   modport master (
      output MemRead, MemWrite, ldIR, ldMDR, ldAcc, IorD, Asrc, AccSrc, PCsrc, PCwrite, jz,
      output ALUop, Bsrc, init_we, init_addr, init_data,
      input  opcode, zero, acc_out, pc_out
   );

   modport slave (
      input  MemRead, MemWrite, ldIR, ldMDR, ldAcc, IorD, Asrc, AccSrc, PCsrc, PCwrite, jz,
      input  ALUop, Bsrc, init_we, init_addr, init_data,
      output opcode, zero, acc_out, pc_out
   );
endinterface

// File: rtl/acc_datapath.sv
// Multicycle accumulator CPU datapath: PC, IR, MDR, Acc, ALU and unified memory.
// Registers update one edge after their enable; no backpressure, the controller's control word is obeyed every cycle.
module acc_datapath #(
   parameter int AW = 5,
   parameter int DW = 8
) (
   input  logic             clk,
   input  logic             rst,
   acc_datapath_if.slave    bus
);

   logic [AW-1:0] pc;
   logic [DW-1:0] ir;
   logic [DW-1:0] mdr;
   logic [DW-1:0] acc;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [DW-1:0] alu_res;
   logic          pc_we;

   always_comb begin
      mem_addr  = bus.IorD ? ir[AW-1:0] : pc;
      mem_rdata = mem[mem_addr];
   end

   always_comb begin
      alu_a = bus.Asrc ? acc : {{(DW-AW){1'b0}}, pc};
      case (bus.Bsrc)
         2'b00:   alu_b = mdr;
         2'b01:   alu_b = DW'(1);
         2'b10:   alu_b = {{(DW-AW){1'b0}}, ir[AW-1:0]};
         default: alu_b = '0;
      endcase
   end

   // Carry and borrow fall off the top; everything is mod 2^DW.
   always_comb begin
      case (bus.ALUop)
         2'b00:   alu_res = alu_a + alu_b;
         2'b01:   alu_res = alu_a - alu_b;
         2'b10:   alu_res = alu_a & alu_b;
         default: alu_res = ~alu_a;
      endcase
   end

   assign pc_we = bus.PCwrite | (bus.jz & (acc == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc  <= '0;
         ir  <= '0;
         mdr <= '0;
         acc <= '0;
      end else begin
         if (bus.ldIR)
            ir <= mem_rdata;
         if (bus.MemRead || bus.ldMDR)
            mdr <= mem_rdata;
         if (bus.ldAcc)
            acc <= bus.AccSrc ? mdr : alu_res;
         if (pc_we)
            pc <= bus.PCsrc ? ir[AW-1:0] : alu_res[AW-1:0];
      end
   end

   // Memory is not reset; the preload port takes priority over a store.
   always_ff @(posedge clk) begin
      if (bus.init_we)
         mem[bus.init_addr] <= bus.init_data;
      else if (bus.MemWrite)
         mem[mem_addr] <= acc;
   end

   assign bus.opcode  = ir[DW-1:AW];
   assign bus.zero    = (acc == '0);
   assign bus.acc_out = acc;
   assign bus.pc_out  = pc;

endmodule

// File: tb/tb_acc_datapath.sv
// Directed bench for acc_datapath: the bench sequences IF/ID/EXEC itself and checks hand-computed results.
module tb_acc_datapath;
   localparam int AW = 5;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   clk_run = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 if (clk_run) clk = ~clk;

   acc_datapath_if #(.AW(AW), .DW(DW)) bus ();

   acc_datapath #(.AW(AW), .DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle_ctl();
      bus.MemRead = 0; bus.MemWrite = 0; bus.ldIR = 0; bus.ldMDR = 0; bus.ldAcc = 0;
      bus.IorD = 0; bus.Asrc = 0; bus.AccSrc = 0; bus.PCsrc = 0; bus.PCwrite = 0; bus.jz = 0;
      bus.ALUop = 2'b00; bus.Bsrc = 2'b00;
      bus.init_we = 0; bus.init_addr = '0; bus.init_data = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      idle_ctl();
      bus.init_we = 1; bus.init_addr = a; bus.init_data = d;
      tick();
      idle_ctl();
   endtask

   task automatic do_if();
      idle_ctl();
      bus.ldIR = 1; bus.IorD = 0; bus.Asrc = 0; bus.Bsrc = 2'b01; bus.ALUop = 2'b00; bus.PCwrite = 1;
      tick();
      idle_ctl();
   endtask

   task automatic do_id();
      idle_ctl();
      bus.IorD = 1; bus.MemRead = 1;
      tick();
      idle_ctl();
   endtask

   task automatic do_ex(input logic [2:0] op, input bit ovr, input logic [AW-1:0] oa,
                        input logic [DW-1:0] od);
      idle_ctl();
      case (op)
         3'b100: begin bus.ldAcc = 1; bus.AccSrc = 1; end
         3'b101: begin bus.MemWrite = 1; bus.IorD = 1; end
         3'b110: begin bus.PCsrc = 1; bus.PCwrite = 1; end
         3'b111: begin bus.PCsrc = 1; bus.jz = 1; end
         default: begin bus.ldAcc = 1; bus.Asrc = 1; bus.Bsrc = 2'b00; bus.ALUop = op[1:0]; end
      endcase
      if (ovr) begin
         bus.init_we = 1; bus.init_addr = oa; bus.init_data = od;
      end
      tick();
      idle_ctl();
   endtask

   // Place the instruction at the current PC, then run its three cycles.
   task automatic run(input logic [DW-1:0] word, input bit ovr, input logic [DW-1:0] od);
      logic [DW-1:0] w;
      w = word;
      preload(bus.pc_out, w);
      do_if();
      do_id();
      do_ex(w[7:5], ovr, w[4:0], od);
   endtask

   initial begin
      idle_ctl();
      #3;
      check("rst_pc", bus.pc_out, 0);
      check("rst_acc", bus.acc_out, 0);
      check("rst_opcode", bus.opcode, 0);
      check("rst_zero", bus.zero, 1);
      #2 rst = 0;
      #2 clk_run = 1;
      #1;

      preload(5'd0, 8'h90);
      preload(5'd16, 8'h2A);
      preload(5'd17, 8'h0F);
      preload(5'd18, 8'hFF);
      preload(5'd19, 8'h01);
      preload(5'd21, 8'h5C);
      preload(5'd22, 8'h3C);

      // LDA 16 from the preloaded mem[0]
      do_if();
      check("fetch_opcode", bus.opcode, 3'b100);
      check("fetch_pc", bus.pc_out, 1);
      do_id();
      do_ex(3'b100, 0, '0, '0);
      check("lda_acc", bus.acc_out, 8'h2A);

      run(8'h11, 0, '0); check("add_acc", bus.acc_out, 8'h39);
      run(8'h31, 0, '0); check("sub_acc", bus.acc_out, 8'h2A);
      run(8'h51, 0, '0); check("and_acc", bus.acc_out, 8'h0A);
      run(8'h60, 0, '0); check("not_acc", bus.acc_out, 8'hF5);
      check("not_zero", bus.zero, 0);
      run(8'h92, 0, '0); check("lda_ff", bus.acc_out, 8'hFF);
      run(8'h13, 0, '0); check("wrap_add_acc", bus.acc_out, 8'h00);
      check("wrap_add_zero", bus.zero, 1);
      check("pc_before_jz", bus.pc_out, 7);

      run(8'hE3, 0, '0); check("jz_taken_pc", bus.pc_out, 3);
      run(8'h93, 0, '0); check("lda_one", bus.acc_out, 8'h01);
      run(8'hE3, 0, '0); check("jz_not_taken_pc", bus.pc_out, 5);
      run(8'hC7, 0, '0); check("jmp_pc", bus.pc_out, 7);

      run(8'h95, 0, '0); check("lda_5c", bus.acc_out, 8'h5C);
      run(8'hB4, 0, '0);
      run(8'h94, 0, '0); check("sta_readback", bus.acc_out, 8'h5C);
      check("pc_after_sta", bus.pc_out, 10);
      run(8'h95, 0, '0);
      run(8'hB4, 1, 8'h77);
      run(8'h94, 0, '0); check("init_priority", bus.acc_out, 8'h77);

      run(8'hDF, 0, '0); check("jmp31_pc", bus.pc_out, 31);
      preload(5'd31, 8'h96);
      do_if();
      check("pc_wrap", bus.pc_out, 0);
      check("wrap_opcode", bus.opcode, 3'b100);
      do_id();
      do_ex(3'b100, 0, '0, '0);
      check("wrap_fetch_acc", bus.acc_out, 8'h3C);

      // Reset pulse between IF and ID of the next instruction
      do_if();
      #2 rst = 1;
      #1;
      check("mid_rst_pc", bus.pc_out, 0);
      check("mid_rst_acc", bus.acc_out, 0);
      check("mid_rst_opcode", bus.opcode, 0);
      check("mid_rst_zero", bus.zero, 1);
      #1 rst = 0;
      do_if();
      check("post_rst_pc", bus.pc_out, 1);
      check("post_rst_opcode", bus.opcode, 3'b100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
